// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: states, PC sources,
// trap causes, instruction classes and the opcode/funct values that decode them.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        PC_SEQ     = 3'd0,
        PC_BRANCH  = 3'd1,
        PC_JUMP    = 3'd2,
        PC_JREG    = 3'd3,
        PC_IRQ_VEC = 3'd4,
        PC_EXC_VEC = 3'd5
    } pcsrc_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_IRQ     = 2'd1,
        CAUSE_ILLEGAL = 2'd2,
        CAUSE_BUS     = 2'd3
    } trap_cause_e;

    typedef enum logic [3:0] {
        CLS_ALU     = 4'd0,
        CLS_LOAD    = 4'd1,
        CLS_STORE   = 4'd2,
        CLS_BRANCH  = 4'd3,
        CLS_J       = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JR      = 4'd6,
        CLS_JALR    = 4'd7,
        CLS_ILLEGAL = 4'd8
    } op_class_e;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_IMM_LO = 6'h08;
    localparam logic [5:0] OP_IMM_HI = 6'h0c;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2a;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface mc_control_fsm_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       OpCode;
    logic [5:0]       Funct;
    logic             IRQ;
    logic             ker;
    logic             mem_ready;
    logic             branch_taken;
    logic [2:0]       state;
    logic             IRWrite;
    logic             PCWrite;
    logic [2:0]       PCSrc;
    logic             RegWrite;
    logic             MemRead;
    logic             MemWrite;
    logic [1:0]       trap_cause;
    logic             instr_done;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  OpCode, Funct, IRQ, ker, mem_ready, branch_taken,
        output state, IRWrite, PCWrite, PCSrc, RegWrite, MemRead, MemWrite,
        output trap_cause, instr_done, instr_count
    );

    modport slave (
        output OpCode, Funct, IRQ, ker, mem_ready, branch_taken,
        input  state, IRWrite, PCWrite, PCSrc, RegWrite, MemRead, MemWrite,
        input  trap_cause, instr_done, instr_count
    );
endinterface

// File: rtl/mc_opclass.sv
// Combinational classification of OpCode/Funct into the sequencing class.
module mc_opclass
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output op_class_e  cls_o
);

    always_comb begin
        cls_o = CLS_ILLEGAL;
        case (op_i)
            OP_RTYPE: begin
                if (funct_i == F_JR) begin
                    cls_o = CLS_JR;
                end else if (funct_i == F_JALR) begin
                    cls_o = CLS_JALR;
                end else if (funct_i inside {F_SLL, F_SRL, F_SRA, [F_ADD:F_NOR], F_SLT}) begin
                    cls_o = CLS_ALU;
                end
            end
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls_o = CLS_BRANCH;
            OP_J:   cls_o = CLS_J;
            OP_JAL: cls_o = CLS_JAL;
            OP_LW:  cls_o = CLS_LOAD;
            OP_SW:  cls_o = CLS_STORE;
            default: begin
                if (op_i inside {[OP_IMM_LO:OP_IMM_HI], OP_LUI}) begin
                    cls_o = CLS_ALU;
                end
            end
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS sequencer: decides when fetch, memory, write-back, PC update and
// trap entry happen. Strobes are Mealy on mem_ready/branch_taken and masked by reset.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    mc_control_fsm_if.master bus
);

    localparam int unsigned     WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    trap_cause_e       trap_cause_q, trap_cause_d;
    op_class_e         cls_q, cls_d, cls_dec;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  instr_count_q;

    logic   ir_write_c, pc_write_c, reg_write_c, mem_read_c, mem_write_c, instr_done_c;
    pcsrc_e pc_src_c;
    logic   mem_wait_c, timeout_c;

    mc_opclass u_opclass (
        .op_i    (bus.OpCode),
        .funct_i (bus.Funct),
        .cls_o   (cls_dec)
    );

    assign mem_wait_c = (mem_read_c | mem_write_c) & ~bus.mem_ready;
    assign timeout_c  = (wait_cnt_q == WAIT_LAST);

    // Next state, trap cause and Mealy strobes
    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        cls_d        = cls_q;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        instr_done_c = 1'b0;
        pc_src_c     = PC_SEQ;

        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end else if (timeout_c) begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_BUS;
                end
            end
            S_DECODE: begin
                cls_d = cls_dec;
                if (bus.IRQ && !bus.ker) begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_IRQ;
                end else if (cls_dec == CLS_ILLEGAL) begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (cls_q)
                    CLS_ALU:              state_d = S_WB;
                    CLS_LOAD, CLS_STORE:  state_d = S_MEM;
                    CLS_BRANCH: begin
                        pc_write_c   = bus.branch_taken;
                        pc_src_c     = PC_BRANCH;
                        instr_done_c = 1'b1;
                    end
                    CLS_J, CLS_JAL: begin
                        pc_write_c   = 1'b1;
                        pc_src_c     = PC_JUMP;
                        reg_write_c  = (cls_q == CLS_JAL);
                        instr_done_c = 1'b1;
                    end
                    CLS_JR, CLS_JALR: begin
                        pc_write_c   = 1'b1;
                        pc_src_c     = PC_JREG;
                        reg_write_c  = (cls_q == CLS_JALR);
                        instr_done_c = 1'b1;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_read_c  = (cls_q == CLS_LOAD);
                mem_write_c = (cls_q == CLS_STORE);
                if (bus.mem_ready) begin
                    state_d      = (cls_q == CLS_LOAD) ? S_WB : S_FETCH;
                    instr_done_c = (cls_q == CLS_STORE);
                end else if (timeout_c) begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_BUS;
                end
            end
            S_WB: begin
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_TRAP: begin
                reg_write_c  = 1'b1;
                pc_write_c   = 1'b1;
                pc_src_c     = (trap_cause_q == CAUSE_IRQ) ? PC_IRQ_VEC : PC_EXC_VEC;
                state_d      = S_FETCH;
                trap_cause_d = CAUSE_NONE;
            end
            default: state_d = S_FETCH;
        endcase

        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (mem_wait_c) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        // Reset abandons any in-flight access without a strobe
        if (reset) begin
            ir_write_c   = 1'b0;
            pc_write_c   = 1'b0;
            reg_write_c  = 1'b0;
            mem_read_c   = 1'b0;
            mem_write_c  = 1'b0;
            instr_done_c = 1'b0;
            pc_src_c     = PC_SEQ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            trap_cause_q  <= CAUSE_NONE;
            cls_q         <= CLS_ALU;
            wait_cnt_q    <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            trap_cause_q  <= trap_cause_d;
            cls_q         <= cls_d;
            wait_cnt_q    <= wait_cnt_d;
            instr_count_q <= instr_count_q + CNT_W'(instr_done_c);
        end
    end

    assign bus.state       = state_q;
    assign bus.trap_cause  = trap_cause_q;
    assign bus.instr_count = instr_count_q;
    assign bus.IRWrite     = ir_write_c;
    assign bus.PCWrite     = pc_write_c;
    assign bus.PCSrc       = pc_src_c;
    assign bus.RegWrite    = reg_write_c;
    assign bus.MemRead     = mem_read_c;
    assign bus.MemWrite    = mem_write_c;
    assign bus.instr_done  = instr_done_c;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed per-cycle scoreboard bench for the multi-cycle MIPS control sequencer.
module tb_mc_control_fsm;

    typedef struct packed {
        logic [2:0]  st;
        logic        irw;
        logic        pcw;
        logic [2:0]  pcs;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [1:0]  cause;
        logic        done;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   cyc_no;
    int   ec;
    exp_t exp_q[$];

    mc_control_fsm_if #(.CNT_W(32)) bus ();

    mc_control_fsm #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL c%0d %s: got %0h expected %0h", cyc_no, tag, got, want);
        end
    endtask

    function automatic exp_t mk(input int st, input bit irw, input bit pcw, input int pcs,
                                input bit rw, input bit mr, input bit mw, input int cause,
                                input bit done, input int cnt);
        exp_t e;
        e.st = 3'(st); e.irw = irw; e.pcw = pcw; e.pcs = 3'(pcs);
        e.rw = rw; e.mr = mr; e.mw = mw; e.cause = 2'(cause);
        e.done = done; e.cnt = 32'(cnt);
        return e;
    endfunction

    // One clock: drive inputs at negedge, queue the expectation, compare once settled
    task automatic cyc(input bit rst, input logic [5:0] op, input logic [5:0] fn,
                       input bit irq, input bit kr, input bit rdy, input bit bt, input exp_t e);
        exp_t x;
        @(negedge clk);
        cyc_no++;
        reset            = rst;
        bus.OpCode       = op;
        bus.Funct        = fn;
        bus.IRQ          = irq;
        bus.ker          = kr;
        bus.mem_ready    = rdy;
        bus.branch_taken = bt;
        exp_q.push_back(e);
        #2;
        x = exp_q.pop_front();
        check("state",      32'(bus.state),      32'(x.st));
        check("IRWrite",    32'(bus.IRWrite),    32'(x.irw));
        check("PCWrite",    32'(bus.PCWrite),    32'(x.pcw));
        check("PCSrc",      32'(bus.PCSrc),      32'(x.pcs));
        check("RegWrite",   32'(bus.RegWrite),   32'(x.rw));
        check("MemRead",    32'(bus.MemRead),    32'(x.mr));
        check("MemWrite",   32'(bus.MemWrite),   32'(x.mw));
        check("trap_cause", 32'(bus.trap_cause), 32'(x.cause));
        check("instr_done", 32'(bus.instr_done), 32'(x.done));
        check("instr_count", bus.instr_count,    x.cnt);
        @(posedge clk);
    endtask

    // Fetch with mem_ready at once followed by a strobe-free DECODE
    task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn, input bit irq, input bit kr);
        cyc(0, op, fn, 0,   kr, 1, 0, mk(0, 1, 1, 0, 0, 1, 0, 0, 0, ec));
        cyc(0, op, fn, irq, kr, 1, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, ec));
    endtask

    // Single-cycle EXEC completion for branches and jumps
    task automatic exec_flow(input logic [5:0] op, input logic [5:0] fn, input bit bt,
                             input bit pcw, input int pcs, input bit rw);
        fetch_decode(op, fn, 0, 0);
        cyc(0, op, fn, 0, 0, 1, bt, mk(2, 0, pcw, pcs, rw, 0, 0, 0, 1, ec));
        ec++;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc_no = 0; ec = 0;
        reset = 1'b1;
        bus.OpCode = '0; bus.Funct = '0; bus.IRQ = 1'b0; bus.ker = 1'b0;
        bus.mem_ready = 1'b0; bus.branch_taken = 1'b0;
        @(posedge clk);

        // Second reset cycle: registered state is known, every strobe masked
        cyc(1, 6'h00, 6'h20, 0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // add: FETCH, DECODE, EXEC, WB
        fetch_decode(6'h00, 6'h20, 0, 0);
        cyc(0, 6'h00, 6'h20, 0, 0, 1, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, ec));
        cyc(0, 6'h00, 6'h20, 0, 0, 1, 0, mk(4, 0, 0, 0, 1, 0, 0, 0, 1, ec));
        ec++;

        // lw: MEM waits two cycles, then WB
        fetch_decode(6'h23, 6'h00, 0, 0);
        cyc(0, 6'h23, 6'h00, 0, 0, 1, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, ec));
        cyc(0, 6'h23, 6'h00, 0, 0, 0, 0, mk(3, 0, 0, 0, 0, 1, 0, 0, 0, ec));
        cyc(0, 6'h23, 6'h00, 0, 0, 0, 0, mk(3, 0, 0, 0, 0, 1, 0, 0, 0, ec));
        cyc(0, 6'h23, 6'h00, 0, 0, 1, 0, mk(3, 0, 0, 0, 0, 1, 0, 0, 0, ec));
        cyc(0, 6'h23, 6'h00, 0, 0, 1, 0, mk(4, 0, 0, 0, 1, 0, 0, 0, 1, ec));
        ec++;

        // beq taken / not taken, then j, jal, jr, jalr
        exec_flow(6'h04, 6'h00, 1, 1, 1, 0);
        exec_flow(6'h04, 6'h00, 0, 0, 1, 0);
        exec_flow(6'h02, 6'h00, 0, 1, 2, 0);
        exec_flow(6'h03, 6'h00, 0, 1, 2, 1);
        exec_flow(6'h00, 6'h08, 0, 1, 3, 0);
        exec_flow(6'h00, 6'h09, 0, 1, 3, 1);

        // sw completing immediately retires in MEM
        fetch_decode(6'h2b, 6'h00, 0, 0);
        cyc(0, 6'h2b, 6'h00, 0, 0, 1, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, ec));
        cyc(0, 6'h2b, 6'h00, 0, 0, 1, 0, mk(3, 0, 0, 0, 0, 0, 1, 0, 1, ec));
        ec++;

        // Unmasked IRQ at DECODE traps to the interrupt vector; IRQ in TRAP is ignored
        fetch_decode(6'h00, 6'h20, 1, 0);
        cyc(0, 6'h00, 6'h20, 1, 0, 1, 0, mk(5, 0, 1, 4, 1, 0, 0, 1, 0, ec));
        cyc(0, 6'h00, 6'h20, 0, 0, 1, 0, mk(0, 1, 1, 0, 0, 1, 0, 0, 0, ec));
        cyc(0, 6'h00, 6'h20, 0, 0, 1, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, ec));
        cyc(0, 6'h00, 6'h20, 0, 0, 1, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, ec));
        cyc(0, 6'h00, 6'h20, 0, 0, 1, 0, mk(4, 0, 0, 0, 1, 0, 0, 0, 1, ec));
        ec++;

        // Kernel mode masks the interrupt
        fetch_decode(6'h00, 6'h20, 1, 1);
        cyc(0, 6'h00, 6'h20, 1, 1, 1, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, ec));
        cyc(0, 6'h00, 6'h20, 1, 1, 1, 0, mk(4, 0, 0, 0, 1, 0, 0, 0, 1, ec));
        ec++;

        // Illegal opcode and illegal R-type funct trap to the exception vector
        fetch_decode(6'h3f, 6'h00, 0, 0);
        cyc(0, 6'h3f, 6'h00, 0, 0, 1, 0, mk(5, 0, 1, 5, 1, 0, 0, 2, 0, ec));
        fetch_decode(6'h00, 6'h01, 0, 0);
        cyc(0, 6'h00, 6'h01, 0, 0, 1, 0, mk(5, 0, 1, 5, 1, 0, 0, 2, 0, ec));

        // sw never ready: 16 MEM cycles with MemWrite, then bus-timeout trap
        fetch_decode(6'h2b, 6'h00, 0, 0);
        cyc(0, 6'h2b, 6'h00, 0, 0, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, ec));
        for (int i = 0; i < 16; i++)
            cyc(0, 6'h2b, 6'h00, 0, 0, 0, 0, mk(3, 0, 0, 0, 0, 0, 1, 0, 0, ec));
        cyc(0, 6'h2b, 6'h00, 0, 0, 0, 0, mk(5, 0, 1, 5, 1, 0, 0, 3, 0, ec));

        // Fetch never ready: 16 FETCH cycles, then bus-timeout trap
        for (int i = 0; i < 16; i++)
            cyc(0, 6'h00, 6'h20, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, ec));
        cyc(0, 6'h00, 6'h20, 0, 0, 0, 0, mk(5, 0, 1, 5, 1, 0, 0, 3, 0, ec));

        // Reset mid-MEM: ready arrives in the reset cycle but nothing strobes or retires
        fetch_decode(6'h2b, 6'h00, 0, 0);
        cyc(0, 6'h2b, 6'h00, 0, 0, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, ec));
        cyc(0, 6'h2b, 6'h00, 0, 0, 0, 0, mk(3, 0, 0, 0, 0, 0, 1, 0, 0, ec));
        cyc(0, 6'h2b, 6'h00, 0, 0, 0, 0, mk(3, 0, 0, 0, 0, 0, 1, 0, 0, ec));
        cyc(1, 6'h2b, 6'h00, 0, 0, 1, 0, mk(3, 0, 0, 0, 0, 0, 0, 0, 0, ec));
        ec = 0;
        cyc(0, 6'h00, 6'h20, 0, 0, 1, 0, mk(0, 1, 1, 0, 0, 1, 0, 0, 0, ec));
        cyc(0, 6'h00, 6'h20, 0, 0, 1, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, ec));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
